alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered execute-stage ALU between two requesters (req0 = pipeline
//  execute, req1 = auxiliary unit) using valid/ready handshakes. Selects and drives the ALU
//  operand/op inputs, tracks the one-cycle ALU latency and returns tagged results on a single
//  response channel with backpressure. Rejects undefined op codes.
// PARAMETERS
//  TAG_W       4   width of requester tag, returned unchanged with the result
//  FIXED_PRIO  0   0 = round-robin between req0/req1; 1 = req0 always wins
//  MAX_OP      18  highest legal alu_op code; codes above it are flagged as errors
// PORTS
//  clock         in   1      system clock, all state on rising edge
//  reset         in   1      asynchronous, active-low reset (0 = reset asserted)
//  reqN_valid    in   1      (N=0,1) request present
//  reqN_ready    out  1      (N=0,1) request accepted this cycle when valid&ready
//  reqN_op       in   6      (N=0,1) ALU op code
//  reqN_a        in   32     (N=0,1) operand 1
//  reqN_b        in   32     (N=0,1) operand 2
//  reqN_tag      in   TAG_W  (N=0,1) requester tag
//  alu_data_in_1 out  32     operand 1 to ALU
//  alu_data_in_2 out  32     operand 2 to ALU
//  alu_op        out  6      op code to ALU
//  alu_data_out  in   32     registered ALU result (valid one cycle after issue)
//  rsp_valid     out  1      response present
//  rsp_ready     in   1      consumer accepts response when valid&ready
//  rsp_id        out  1      requester index of response
//  rsp_tag       out  TAG_W  tag of response
//  rsp_data      out  32     result; 0 when rsp_err
//  rsp_err       out  1      op code > MAX_OP
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer favours req0, in-flight/hold cleared.
//    Reset mid-operation discards any in-flight or held result; no response emitted.
//  - States: IDLE (nothing in ALU), BUSY (result in ALU this cycle), HOLD (result captured,
//    waiting rsp_ready).
//  - can_issue = (IDLE) | (BUSY & rsp_ready). Never issue in HOLD.
//  - Grant (comb.): if can_issue, pick among valid requesters; both valid -> FIXED_PRIO=1: req0;
//    else the one not granted last. reqN_ready = can_issue & grantN. One grant per cycle max.
//  - Issue cycle C: alu_data_in_1/2, alu_op driven from granted request; id/tag/err stored.
//    When not issuing, ALU inputs hold last issued values.
//  - Cycle C+1 (BUSY): rsp_valid=1, rsp_data = alu_data_out (0 if err), id/tag from store.
//    rsp_ready=1: response done; next state BUSY if issue in C+1, else IDLE.
//    rsp_ready=0: capture alu_data_out/id/tag/err into hold regs -> HOLD.
//  - HOLD: rsp_valid=1 from hold regs, stable until rsp_ready; then -> IDLE (issue resumes
//    the following cycle).
//  - Throughput: one op per cycle with rsp_ready held 1; latency issue->response 1 cycle.
//  - rr pointer updates only on an accepted request. Error ops still occupy an ALU slot.
//  - No arithmetic in this block; widths pass through unchanged.
// TESTING
//  - Reset low mid-BUSY with req0 ADD 3+4 issued -> no rsp_valid, all outputs 0 after reset.
//  - req0 only, ADD(5,7,tag 2) then SUB(9,4,tag 3) back-to-back, rsp_ready=1 -> rsp_data 12
//    then 5, rsp_id 0, tags 2,3, one cycle apart.
//  - Both valid every cycle, FIXED_PRIO=0 -> grants alternate 0,1,0,1; FIXED_PRIO=1 -> req1
//    never granted while req0 valid.
//  - Issue XOR(0xF0,0xFF); rsp_ready=0 for 3 cycles -> rsp_data 0x0F held stable, both
//    reqN_ready=0 throughout, new issue only cycle after acceptance.
//  - req1 op=25 tag 7 -> rsp_err=1, rsp_data=0, rsp_id=1, rsp_tag=7.
//  - Response accepted in BUSY while req0 valid -> new issue same cycle, no bubble.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals shared between the ALU arbiter and its environment.
// slave = arbiter view, master = requesters/ALU/consumer view.
interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [5:0]       req0_op;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [5:0]       req1_op;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic [31:0]      alu_data_in_1;
  logic [31:0]      alu_data_in_2;
  logic [5:0]       alu_op;
  logic [31:0]      alu_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  alu_data_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_data_in_1, alu_data_in_2, alu_op,
    output rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output alu_data_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_data_in_1, alu_data_in_2, alu_op,
    input  rsp_valid, rsp_id, rsp_tag, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one registered (1-cycle) ALU between two requesters and returns tagged results
// on a single backpressured response channel; op codes above MAX_OP are flagged as errors.
module alu_arbiter #(
  parameter int          TAG_W      = 4,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_OP     = 18
) (
  input  logic           clock,
  input  logic           reset,
  alu_arbiter_if.slave   bus
);

  localparam logic [5:0] LP_MAX_OP = 6'(MAX_OP);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  state_t           r_state;
  logic             r_prio1;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [5:0]       r_op;
  logic             r_id;
  logic             r_err;
  logic [TAG_W-1:0] r_tag;
  logic             r_hid;
  logic             r_herr;
  logic [TAG_W-1:0] r_htag;
  logic [31:0]      r_hdata;

  logic             w_can_issue;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_issue;
  logic             w_sel;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [5:0]       w_op;
  logic [TAG_W-1:0] w_tag;
  logic             w_err;

  // Issue is gated by reset so nothing is accepted while reset is asserted.
  always_comb begin
    w_can_issue = reset && ((r_state == S_IDLE) || ((r_state == S_BUSY) && bus.rsp_ready));
    w_gnt0      = bus.req0_valid && (!bus.req1_valid || FIXED_PRIO || !r_prio1);
    w_gnt1      = bus.req1_valid && !w_gnt0;
    w_issue     = w_can_issue && (w_gnt0 || w_gnt1);
    w_sel       = w_gnt1;
    w_a         = w_sel ? bus.req1_a   : bus.req0_a;
    w_b         = w_sel ? bus.req1_b   : bus.req0_b;
    w_op        = w_sel ? bus.req1_op  : bus.req0_op;
    w_tag       = w_sel ? bus.req1_tag : bus.req0_tag;
    w_err       = (w_op > LP_MAX_OP);
  end

  always_comb begin
    bus.req0_ready    = w_can_issue && w_gnt0;
    bus.req1_ready    = w_can_issue && w_gnt1;
    bus.alu_data_in_1 = w_issue ? w_a  : r_a;
    bus.alu_data_in_2 = w_issue ? w_b  : r_b;
    bus.alu_op        = w_issue ? w_op : r_op;
  end

  always_comb begin
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = 1'b0;
    bus.rsp_tag   = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    case (r_state)
      S_BUSY: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = r_id;
        bus.rsp_tag   = r_tag;
        bus.rsp_err   = r_err;
        bus.rsp_data  = r_err ? '0 : bus.alu_data_out;
      end
      S_HOLD: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = r_hid;
        bus.rsp_tag   = r_htag;
        bus.rsp_err   = r_herr;
        bus.rsp_data  = r_hdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_prio1 <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_tag   <= '0;
      r_hid   <= 1'b0;
      r_herr  <= 1'b0;
      r_htag  <= '0;
      r_hdata <= '0;
    end else begin
      if (w_issue) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_op    <= w_op;
        r_id    <= w_sel;
        r_tag   <= w_tag;
        r_err   <= w_err;
        r_prio1 <= !w_sel;
      end
      case (r_state)
        S_IDLE: if (w_issue) r_state <= S_BUSY;
        S_BUSY: begin
          if (bus.rsp_ready) begin
            r_state <= w_issue ? S_BUSY : S_IDLE;
          end else begin
            // The ALU output is only valid for one cycle, so a stalled result is captured here.
            r_hid   <= r_id;
            r_htag  <= r_tag;
            r_herr  <= r_err;
            r_hdata <= r_err ? '0 : bus.alu_data_out;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: if (bus.rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference model; a behavioural registered ALU sits on each DUT's ALU port.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int unsigned vectors;
  int unsigned miscompares;

  alu_arbiter_if #(.TAG_W(4)) b0 ();
  alu_arbiter_if #(.TAG_W(4)) f1 ();

  alu_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b0), .MAX_OP(18)) dut_rr (
    .clock (clk),
    .reset (rst_n),
    .bus   (b0)
  );

  alu_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b1), .MAX_OP(18)) dut_fixed (
    .clock (clk),
    .reset (rst_n),
    .bus   (f1)
  );

  typedef struct packed {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      default: return (a + (b << 1)) ^ {26'd0, op};
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) b0.alu_data_out <= alu_f(b0.alu_op, b0.alu_data_in_1, b0.alu_data_in_2);
  always @(posedge clk) f1.alu_data_out <= alu_f(f1.alu_op, f1.alu_data_in_1, f1.alu_data_in_2);

  task automatic clear_inputs();
    b0.req0_valid = 1'b0; b0.req0_op = '0; b0.req0_a = '0; b0.req0_b = '0; b0.req0_tag = '0;
    b0.req1_valid = 1'b0; b0.req1_op = '0; b0.req1_a = '0; b0.req1_b = '0; b0.req1_tag = '0;
    b0.rsp_ready  = 1'b1;
    f1.req0_valid = 1'b0; f1.req0_op = '0; f1.req0_a = '0; f1.req0_b = '0; f1.req0_tag = '0;
    f1.req1_valid = 1'b0; f1.req1_op = '0; f1.req1_a = '0; f1.req1_b = '0; f1.req1_tag = '0;
    f1.rsp_ready  = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic quiesce();
    @(posedge clk); #1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [110:0] outs;
    @(posedge clk); #1;
    b0.req0_valid = 1'b1; b0.req0_op = 6'd0; b0.req0_a = 32'd3; b0.req0_b = 32'd4;
    b0.req0_tag = 4'd5; b0.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b0.req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_issue: req0_ready=%b expected 1", b0.req0_ready);
    end
    @(posedge clk); #1;
    b0.req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (b0.rsp_valid !== 1'b1 || b0.rsp_data !== 32'd7) begin
      miscompares++;
      $display("FAIL reset_busy: rsp_valid=%b data=%0d expected 1/7", b0.rsp_valid, b0.rsp_data);
    end
    rst_n = 1'b0;
    #1;
    outs = {b0.req0_ready, b0.req1_ready, b0.alu_data_in_1, b0.alu_data_in_2, b0.alu_op,
            b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data, b0.rsp_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++; $display("FAIL reset_outs_during: outputs=%h expected 0", outs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    outs = {b0.req0_ready, b0.req1_ready, b0.alu_data_in_1, b0.alu_data_in_2, b0.alu_op,
            b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data, b0.rsp_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++; $display("FAIL reset_outs_after: outputs=%h expected 0", outs);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    b0.req0_valid = 1'b1; b0.req0_op = 6'd0; b0.req0_a = 32'd5; b0.req0_b = 32'd7;
    b0.req0_tag = 4'd2; b0.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b0.req0_ready !== 1'b1 || b0.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_issue1: ready=%b rsp_valid=%b expected 1/0", b0.req0_ready, b0.rsp_valid);
    end
    @(posedge clk); #1;
    b0.req0_op = 6'd1; b0.req0_a = 32'd9; b0.req0_b = 32'd4; b0.req0_tag = 4'd3;
    @(negedge clk);
    vectors++;
    if ({b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data} !== {1'b1, 1'b0, 4'd2, 32'd12}) begin
      miscompares++;
      $display("FAIL b2b_rsp1: valid=%b id=%b tag=%0d data=%0d expected 1/0/2/12",
               b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data);
    end
    vectors++;
    if (b0.req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_nobubble: req0_ready=%b expected 1", b0.req0_ready);
    end
    @(posedge clk); #1;
    b0.req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data} !== {1'b1, 1'b0, 4'd3, 32'd5}) begin
      miscompares++;
      $display("FAIL b2b_rsp2: valid=%b id=%b tag=%0d data=%0d expected 1/0/3/5",
               b0.rsp_valid, b0.rsp_id, b0.rsp_tag, b0.rsp_data);
    end
    @(negedge clk);
    vectors++;
    if (b0.rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain: rsp_valid=%b expected 0", b0.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      b0.req0_valid = 1'b1; b0.req0_op = 6'd0; b0.req0_a = i; b0.req0_b = 32'd1;
      b0.req0_tag = 4'(i);
      b0.req1_valid = 1'b1; b0.req1_op = 6'd1; b0.req1_a = i; b0.req1_b = 32'd1;
      b0.req1_tag = 4'(i + 8);
      f1.req0_valid = 1'b1; f1.req0_op = 6'd2; f1.req0_a = $urandom; f1.req0_b = $urandom;
      f1.req1_valid = 1'b1; f1.req1_op = 6'd3; f1.req1_a = $urandom; f1.req1_b = $urandom;
      @(negedge clk);
      vectors++;
      if ({b0.req0_ready, b0.req1_ready} !== {(i % 2) == 0, (i % 2) == 1}) begin
        miscompares++;
        $display("FAIL rr_grant cycle %0d: ready0/1=%b%b expected %b%b", i,
                 b0.req0_ready, b0.req1_ready, (i % 2) == 0, (i % 2) == 1);
      end
      if (i > 0) begin
        vectors++;
        if (b0.rsp_valid !== 1'b1 || b0.rsp_id !== 1'((i - 1) % 2)) begin
          miscompares++;
          $display("FAIL rr_rsp_id cycle %0d: valid=%b id=%b expected 1/%0d", i,
                   b0.rsp_valid, b0.rsp_id, (i - 1) % 2);
        end
      end
      vectors++;
      if ({f1.req0_ready, f1.req1_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL fixed_grant cycle %0d: ready0/1=%b%b expected 10", i,
                 f1.req0_ready, f1.req1_ready);
      end
    end
    quiesce();
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    b0.req0_valid = 1'b1; b0.req0_op = 6'd4; b0.req0_a = 32'hF0; b0.req0_b = 32'hFF;
    b0.req0_tag = 4'd1; b0.rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (b0.req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_issue: req0_ready=%b expected 1", b0.req0_ready);
    end
    @(posedge clk); #1;
    b0.req0_op = 6'd0; b0.req0_a = 32'd1; b0.req0_b = 32'd1; b0.req0_tag = 4'd9;
    b0.req1_valid = 1'b1; b0.req1_op = 6'd0; b0.req1_a = 32'd2; b0.req1_b = 32'd2;
    b0.req1_tag = 4'd10;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 3) begin
        @(posedge clk); #1;
        b0.rsp_ready = 1'b1;
      end
      @(negedge clk);
      vectors++;
      if ({b0.rsp_valid, b0.rsp_tag, b0.rsp_data, b0.req0_ready, b0.req1_ready} !==
          {1'b1, 4'd1, 32'h0F, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_stable step %0d: valid=%b tag=%0d data=%h ready0/1=%b%b expected 1/1/0f/00",
                 k, b0.rsp_valid, b0.rsp_tag, b0.rsp_data, b0.req0_ready, b0.req1_ready);
      end
    end
    @(negedge clk);
    vectors++;
    if ({b0.rsp_valid, b0.req0_ready, b0.req1_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL hold_resume: valid=%b ready0/1=%b%b expected 0/01",
               b0.rsp_valid, b0.req0_ready, b0.req1_ready);
    end
    quiesce();
  endtask

  task automatic test_error();
    @(posedge clk); #1;
    b0.req1_valid = 1'b1; b0.req1_op = 6'd25; b0.req1_a = $urandom; b0.req1_b = $urandom;
    b0.req1_tag = 4'd7; b0.rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (b0.req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL err_issue: req1_ready=%b expected 1", b0.req1_ready);
    end
    @(posedge clk); #1;
    b0.req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.rsp_id, b0.rsp_tag} !==
        {1'b1, 1'b1, 32'd0, 1'b1, 4'd7}) begin
      miscompares++;
      $display("FAIL err_rsp: valid=%b err=%b data=%h id=%b tag=%0d expected 1/1/0/1/7",
               b0.rsp_valid, b0.rsp_err, b0.rsp_data, b0.rsp_id, b0.rsp_tag);
    end
    quiesce();
  endtask

  task automatic test_random(input int unsigned n);
    exp_t        q[$];
    exp_t        e;
    exp_t        got;
    int unsigned age;
    bit          fav1;
    bit          can, g0, g1;
    logic [5:0]  op;
    do_reset();
    age  = 0;
    fav1 = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      b0.req0_valid = ($urandom_range(0, 3) != 0);
      b0.req0_op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 20));
      b0.req0_a     = $urandom; b0.req0_b = $urandom; b0.req0_tag = 4'($urandom);
      b0.req1_valid = ($urandom_range(0, 3) != 0);
      b0.req1_op    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 20));
      b0.req1_a     = $urandom; b0.req1_b = $urandom; b0.req1_tag = 4'($urandom);
      b0.rsp_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      can = (q.size() == 0) || (age == 1 && b0.rsp_ready);
      g0  = can && b0.req0_valid && (!b0.req1_valid || !fav1);
      g1  = can && b0.req1_valid && !g0;
      vectors++;
      if ({b0.req0_ready, b0.req1_ready} !== {g0, g1}) begin
        miscompares++;
        $display("FAIL rand_grant cycle %0d: ready0/1=%b%b expected %b%b", i,
                 b0.req0_ready, b0.req1_ready, g0, g1);
      end
      vectors++;
      if (b0.rsp_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_valid cycle %0d: rsp_valid=%b expected %b", i, b0.rsp_valid,
                 q.size() != 0);
      end
      if (q.size() != 0) begin
        got = {b0.rsp_id, b0.rsp_tag, b0.rsp_data, b0.rsp_err};
        vectors++;
        if (got !== q[0]) begin
          miscompares++;
          $display("FAIL rand_rsp cycle %0d: id/tag/data/err=%h expected %h", i, got, q[0]);
        end
        if (b0.rsp_ready) void'(q.pop_front());
        else age++;
      end
      if (g0 || g1) begin
        op    = g1 ? b0.req1_op : b0.req0_op;
        e.id  = g1;
        e.tag = g1 ? b0.req1_tag : b0.req0_tag;
        e.err = (op > 6'd18);
        e.data = e.err ? 32'd0 : (g1 ? alu_f(op, b0.req1_a, b0.req1_b)
                                     : alu_f(op, b0.req0_a, b0.req0_b));
        q.push_back(e);
        age  = 1;
        fav1 = g0;
      end
    end
    quiesce();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_round_robin();
    test_hold();
    test_error();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
